fetch_pipe: RTL

- Upstream front end of the pipelined MIPS core.
- Owns the PC and the instruction-memory address, and registers the fetched word into the ID slot.
- Keeps the in-flight instruction words for the EX and MEM slots. These feed the decode/control stage as its current instruction plus the one-back and two-back instruction words used for forwarding decisions.
- Applies hazard stalls (bubble into EX) and taken jump/branch redirects (flush of the wrong-path fetch).

---
 rtl/fetch_pipe.sv | 86 ++++++++
 1 files changed

// File: rtl/fetch_pipe.sv
// fetch_pipe: PC/instruction-fetch front end feeding the ID, EX and MEM instruction slots.
// Latency: an imem word is on `instruction` one edge after it is fetched, `ex_int_forward` +1, `mem_int_forward` +2.
// Backpressure: stall holds PC/ID and bubbles EX; redirect (priority) reloads PC and flushes the ID fetch.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   imem_addr / imem_data         fetch address (the PC register) and its combinational read data
//   stall                         hazard hold request from decode
//   redirect / redirect_pc        taken jump/branch and its target (low two bits ignored)
//   instruction                   ID-slot word
//   ex_int_forward                EX-slot word (one back)
//   mem_int_forward               MEM-slot word (two back)
//   pc_plus4_id / valid_id        PC+4 and valid flag of the ID-slot word
//   stall_cnt / flush_cnt         saturating event counters
module fetch_pipe #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      instruction,
    output logic [31:0]      ex_int_forward,
    output logic [31:0]      mem_int_forward,
    output logic [31:0]      pc_plus4_id,
    output logic             valid_id,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0] pc;
    logic [31:0] pc_next_seq;

    // Sequential PC; 32-bit add wraps naturally at 2^32.
    assign pc_next_seq = pc + 32'd4;
    assign imem_addr   = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc              <= RESET_PC;
            instruction     <= NOP_WORD;
            ex_int_forward  <= NOP_WORD;
            mem_int_forward <= NOP_WORD;
            pc_plus4_id     <= RESET_PC;
            valid_id        <= 1'b0;
            stall_cnt       <= '0;
            flush_cnt       <= '0;
        end else begin
            // MEM slot always takes the EX word, whatever else happens.
            mem_int_forward <= ex_int_forward;

            if (redirect) begin
                pc          <= {redirect_pc[31:2], 2'b00};
                // Wrong-path fetch of this cycle is dropped.
                instruction <= NOP_WORD;
                valid_id    <= 1'b0;
                pc_plus4_id <= pc_next_seq;
                // Delay-slot word proceeds unless decode also asked for a hold.
                ex_int_forward <= stall ? NOP_WORD : instruction;
                if (flush_cnt != CNT_MAX) begin
                    flush_cnt <= flush_cnt + 1'b1;
                end
            end else if (stall) begin
                // PC and ID hold; a single bubble enters EX each stalled cycle.
                ex_int_forward <= NOP_WORD;
                if (stall_cnt != CNT_MAX) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end else begin
                pc             <= pc_next_seq;
                instruction    <= imem_data;
                pc_plus4_id    <= pc_next_seq;
                valid_id       <= 1'b1;
                ex_int_forward <= instruction;
            end
        end
    end

endmodule
